// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage between execute and a word-wide data memory.
// Request side : req_valid/req_ready handshake; req_we, req_byte, req_signed, req_addr (byte), req_wdata.
// Response side: resp_valid one-cycle pulse with resp_rdata (formatted load data) and resp_err (misaligned word).
// Memory side  : mem_we, mem_re, mem_addr (word), mem_wdata, mem_rdata (combinational read).
module load_store_unit #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_byte,
  input  logic              req_signed,
  input  logic [ADDR_W:0]   req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, MERGE} state_t;
  state_t state, state_nx;
  logic              we_q, byte_q, signed_q;
  logic [ADDR_W:0]   addr_q;
  logic [DATA_W-1:0] wdata_q, merge_q;
  logic              mis, byte_store;
  logic [7:0]        lane;
  logic [DATA_W-1:0] fmt, merged;

  always_comb begin
    mis        = !byte_q && addr_q[0];
    byte_store = we_q && byte_q;
    lane       = addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0];
    fmt        = byte_q ? {{(DATA_W-8){signed_q & lane[7]}}, lane} : mem_rdata;
    // Little-endian lanes: only the addressed byte is replaced, the other comes from the read.
    merged     = addr_q[0] ? {wdata_q[7:0], merge_q[7:0]} : {merge_q[15:8], wdata_q[7:0]};
    req_ready  = state == IDLE;
    mem_addr   = addr_q[ADDR_W:1];
    mem_re     = state == ACCESS && !mis && (!we_q || byte_q);
    mem_we     = state == MERGE || (state == ACCESS && !mis && we_q && !byte_q);
    mem_wdata  = !mem_we ? '0 : state == MERGE ? merged : wdata_q;
    state_nx   = state == IDLE   ? (req_valid ? ACCESS : IDLE) :
                 state == ACCESS ? (byte_store && !mis ? MERGE : IDLE) : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      we_q       <= 1'b0;
      byte_q     <= 1'b0;
      signed_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
    end else begin
      state      <= state_nx;
      resp_valid <= 1'b0;
      if (state == IDLE && req_valid) begin
        we_q     <= req_we;
        byte_q   <= req_byte;
        signed_q <= req_signed;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      if (state == ACCESS) begin
        if (byte_store) merge_q <= mem_rdata;
        else begin
          resp_valid <= 1'b1;
          resp_err   <= mis;
          resp_rdata <= (!we_q && !mis) ? fmt : '0;
        end
      end
      if (state == MERGE) begin
        resp_valid <= 1'b1;
        resp_err   <= 1'b0;
        resp_rdata <= '0;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit with a behavioural 1024x16 memory.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_byte = 1'b0, req_signed = 1'b0;
  logic [10:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, mem_we, mem_re;
  logic [15:0] resp_rdata, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;
  logic [15:0] mem [1024];
  int checks = 0;
  int errors = 0;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_byte(req_byte), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_we(mem_we), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem_re ? mem[mem_addr] : 16'h0000;
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic send(input logic we, input logic byt, input logic sgn, input logic [10:0] addr, input logic [15:0] wd);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: req_ready=%b expected 1", req_ready);
    end
    req_we = we; req_byte = byt; req_signed = sgn; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_wdata = 16'hXXXX ^ 16'h0;
    req_addr = 11'h7FF;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({mem_we, mem_re, resp_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_hold: we/re/valid=%b expected 000", {mem_we, mem_re, resp_valid});
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, mem_we, mem_re} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_release: ready/valid/we/re=%b expected 1000", {req_ready, resp_valid, mem_we, mem_re});
    end
  endtask

  task automatic test_word_store_load;
    send(1'b1, 1'b0, 1'b0, 11'h010, 16'hBEEF);
    @(negedge clk);
    checks++;
    if ({mem_we, mem_re, mem_addr, mem_wdata, resp_valid} !== {1'b1, 1'b0, 10'h008, 16'hBEEF, 1'b0}) begin
      errors++;
      $display("FAIL wstore_mem: we=%b re=%b addr=%h wdata=%h valid=%b expected 1 0 008 beef 0", mem_we, mem_re, mem_addr, mem_wdata, resp_valid);
    end
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_err, resp_rdata, req_ready, mem_we} !== {1'b1, 1'b0, 16'h0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wstore_resp: valid=%b err=%b rdata=%h ready=%b we=%b expected 1 0 0000 1 0", resp_valid, resp_err, resp_rdata, req_ready, mem_we);
    end
    send(1'b0, 1'b0, 1'b0, 11'h010, 16'h0000);
    @(negedge clk);
    checks++;
    if ({mem_re, mem_we, mem_addr, resp_valid} !== {1'b1, 1'b0, 10'h008, 1'b0}) begin
      errors++;
      $display("FAIL wload_mem: re=%b we=%b addr=%h valid=%b expected 1 0 008 0", mem_re, mem_we, mem_addr, resp_valid);
    end
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 16'hBEEF}) begin
      errors++;
      $display("FAIL wload_resp: valid=%b err=%b rdata=%h expected 1 0 beef", resp_valid, resp_err, resp_rdata);
    end
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_rdata} !== {1'b0, 16'hBEEF}) begin
      errors++;
      $display("FAIL wload_pulse: valid=%b rdata=%h expected 0 beef (one pulse, held data)", resp_valid, resp_rdata);
    end
  endtask

  task automatic test_byte_loads;
    logic [10:0] addrs [3] = '{11'h011, 11'h011, 11'h010};
    logic        sgns  [3] = '{1'b1, 1'b0, 1'b1};
    logic [15:0] exps  [3] = '{16'hFF80, 16'h0080, 16'hFFA5};
    mem[8] = 16'h80A5;
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 1'b1, sgns[i], addrs[i], 16'h0000);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, exps[i]}) begin
        errors++;
        $display("FAIL byte_load_%0d: valid=%b err=%b rdata=%h expected 1 0 %h", i, resp_valid, resp_err, resp_rdata, exps[i]);
      end
    end
  endtask

  task automatic test_byte_store;
    mem[8] = 16'h1234;
    send(1'b1, 1'b1, 1'b0, 11'h011, 16'hAACD);
    @(negedge clk);
    checks++;
    if ({mem_re, mem_we, mem_addr, resp_valid} !== {1'b1, 1'b0, 10'h008, 1'b0}) begin
      errors++;
      $display("FAIL bstore_read: re=%b we=%b addr=%h valid=%b expected 1 0 008 0", mem_re, mem_we, mem_addr, resp_valid);
    end
    @(negedge clk);
    checks++;
    if ({mem_we, mem_re, mem_wdata, resp_valid, req_ready} !== {1'b1, 1'b0, 16'hCD34, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL bstore_write: we=%b re=%b wdata=%h valid=%b ready=%b expected 1 0 cd34 0 0", mem_we, mem_re, mem_wdata, resp_valid, req_ready);
    end
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_err, mem_we, mem[8]} !== {1'b1, 1'b0, 1'b0, 16'hCD34}) begin
      errors++;
      $display("FAIL bstore_resp: valid=%b err=%b we=%b mem=%h expected 1 0 0 cd34", resp_valid, resp_err, mem_we, mem[8]);
    end
    send(1'b1, 1'b1, 1'b0, 11'h010, 16'h5577);
    repeat (3) @(negedge clk);
    send(1'b0, 1'b0, 1'b0, 11'h010, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_rdata} !== {1'b1, 16'hCD77}) begin
      errors++;
      $display("FAIL bstore_low_lane: valid=%b rdata=%h expected 1 cd77", resp_valid, resp_rdata);
    end
  endtask

  task automatic test_misaligned;
    mem[9] = 16'h5555;
    send(1'b0, 1'b0, 1'b0, 11'h013, 16'h0000);
    @(negedge clk);
    checks++;
    if ({mem_re, mem_we} !== 2'b00) begin
      errors++;
      $display("FAIL mis_load_mem: re=%b we=%b expected 0 0", mem_re, mem_we);
    end
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL mis_load_resp: valid=%b err=%b rdata=%h expected 1 1 0000", resp_valid, resp_err, resp_rdata);
    end
    send(1'b1, 1'b0, 1'b0, 11'h013, 16'h1111);
    @(negedge clk);
    checks++;
    if ({mem_re, mem_we} !== 2'b00) begin
      errors++;
      $display("FAIL mis_store_mem: re=%b we=%b expected 0 0", mem_re, mem_we);
    end
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_err, mem[9]} !== {1'b1, 1'b1, 16'h5555}) begin
      errors++;
      $display("FAIL mis_store_resp: valid=%b err=%b mem=%h expected 1 1 5555", resp_valid, resp_err, mem[9]);
    end
  endtask

  task automatic test_reset_merge;
    mem[8] = 16'h1234;
    send(1'b1, 1'b1, 1'b0, 11'h010, 16'h00EE);
    @(negedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (mem_we !== 1'b1) begin
      errors++;
      $display("FAIL rst_merge_pre: we=%b expected 1", mem_we);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_we, mem_re} !== 2'b00) begin
      errors++;
      $display("FAIL rst_merge_drop: we=%b re=%b expected 0 0", mem_we, mem_re);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem[8], resp_valid, req_ready} !== {16'h1234, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rst_merge_after: mem=%h valid=%b ready=%b expected 1234 0 1", mem[8], resp_valid, req_ready);
    end
    send(1'b0, 1'b0, 1'b0, 11'h7FE, 16'h0000);
    @(negedge clk);
    checks++;
    if ({mem_re, mem_addr} !== {1'b1, 10'h3FF}) begin
      errors++;
      $display("FAIL top_addr: re=%b addr=%h expected 1 3ff", mem_re, mem_addr);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[10'h3FF] = 16'h4242;
    test_reset;
    test_word_store_load;
    test_byte_loads;
    test_byte_store;
    test_misaligned;
    test_reset_merge;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage between the execute stage (ALU effective address, store data) and the 1024x16 word data memory.
- Accepts one load/store request at a time over a valid/ready handshake.
- Converts a byte address into a word address and performs word or byte accesses. Byte stores use a read-modify-write sequence because the memory is word-wide.
- Returns formatted load data, with sign/zero extension, to writeback via a one-cycle response pulse.

Parameters:
- ADDR_W, 10, word-address width of the data memory (1024 words); the byte address is ADDR_W+1 bits.
- DATA_W, 16, memory word width; byte lanes are fixed at 8 bits.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  execute stage presents a request
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_we  input  1  1 = store, 0 = load
- req_byte  input  1  1 = byte access, 0 = word access
- req_signed  input  1  byte load sign-extends when 1, zero-extends when 0
- req_addr  input  ADDR_W+1  byte address; bit 0 selects the byte lane
- req_wdata  input  DATA_W  store data (byte stores use bits [7:0])
- resp_valid  output  1  one-cycle pulse: request complete
- resp_rdata  output  DATA_W  formatted load data; 0 for stores and errors
- resp_err  output  1  misaligned word access, valid with resp_valid
- mem_we  output  1  memory write enable
- mem_re  output  1  memory read enable
- mem_addr  output  ADDR_W  word address, equal to req_addr[ADDR_W:1] as latched
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data (combinational read, valid in the same cycle as mem_re)

Behaviour:
- Clock is clk; reset is rst_n, asynchronous and active-low.
- Reset values: state IDLE, resp_valid 0, resp_rdata 0, resp_err 0, all request latches 0.
  - mem_we, mem_re, mem_addr and mem_wdata decode from state and latches, so they are 0 during reset.
- Handshake: a request is accepted on a rising edge with req_valid && req_ready. Address, data and control are latched at that edge; request inputs are ignored afterwards.
- States and transitions:
  - IDLE: req_ready=1. On accept, go to ACCESS.
  - ACCESS: mem_addr driven from the latched address.
    - Misaligned word access (req_byte=0, addr[0]=1): no mem_we/mem_re; go to IDLE; resp_valid=1 and resp_err=1 next cycle.
    - Word store: mem_we=1, mem_wdata = latched wdata; go to IDLE; resp_valid next cycle.
    - Load: mem_re=1; mem_rdata formatted and registered into resp_rdata at the edge; go to IDLE; resp_valid next cycle.
    - Byte store: mem_re=1; mem_rdata captured into a merge register; go to MERGE.
  - MERGE: mem_we=1. mem_wdata = merge register with the selected lane replaced by wdata[7:0]; the other lane is unchanged. Go to IDLE; resp_valid next cycle.
- Byte lanes are little-endian: addr[0]=0 selects bits [7:0]; addr[0]=1 selects bits [15:8].
- Load formatting:
  - Word load returns mem_rdata unchanged.
  - Byte load with req_signed=1 returns the lane sign-extended to 16 bits.
  - Byte load with req_signed=0 returns the lane zero-extended.
- Latency, with the accept edge at cycle T:
  - Word load, word store and error: memory op in T+1, resp_valid in T+2.
  - Byte load: same as word load.
  - Byte store: read in T+1, write in T+2, resp_valid in T+3.
- resp_valid is high for exactly one cycle per request. resp_rdata and resp_err hold until the next response.
- A new request may be accepted in the same cycle resp_valid is high, because the state is back in IDLE. Back-to-back throughput is one request per 2 cycles (3 for byte stores).
- mem_we and mem_re are never asserted together. At most one memory write is issued per store.
- Reset mid-operation: entering reset in ACCESS or MERGE abandons the request. No write is issued after reset assertion, no resp_valid is produced, and the unit returns to IDLE.
- Address wrap: word address 1023 is a normal address; there is no increment or wrap logic.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release -> req_ready=1; resp_valid, mem_we and mem_re all 0.
- Word store then load: store 16'hBEEF at byte address 0x010 -> mem_we in T+1 with mem_addr=0x008, resp_valid in T+2. Load the same address -> resp_rdata=16'hBEEF, resp_err=0.
- Byte loads: word 0x008 holds 16'h80A5.
  - Signed byte load at 0x011 -> 16'hFF80.
  - Unsigned byte load at 0x011 -> 16'h0080.
  - Signed byte load at 0x010 -> 16'hFFA5.
- Byte store RMW: word 0x008 holds 16'h1234; byte store 8'hCD at 0x011 -> read in T+1, write 16'hCD34 in T+2, resp_valid in T+3. A subsequent word load returns 16'hCD34.
- Misaligned word access: load at 0x013 -> no mem_re/mem_we, resp_valid=1 with resp_err=1 and resp_rdata=0 in T+2. A misaligned word store leaves memory unchanged.
- Reset during MERGE: byte store; assert rst_n=0 in the MERGE cycle before the edge -> mem_we drops immediately, memory is unchanged, no resp_valid, and req_ready=1 after release.
